// File: rtl/windowed_reg_file_if.sv
// Bus bundle for windowed_reg_file: window control, two read ports, writeback port and clear request.
// The master drives requests and addresses; the slave (register file) drives read data, cur_wnd and busy.
interface windowed_reg_file_if #(
    parameter int DATA_W       = 16,
    parameter int NUM_WIN      = 4,
    parameter int REGS_PER_WIN = 4
);
    localparam int WIN_W  = $clog2(NUM_WIN);
    localparam int ADDR_W = $clog2(REGS_PER_WIN);

    logic              ld_wnd;
    logic [WIN_W-1:0]  wnd_in;
    logic [WIN_W-1:0]  cur_wnd;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [WIN_W-1:0]  wr_wnd;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic [WIN_W-1:0]  clr_win;
    logic              busy;

    modport master (
        output ld_wnd, wnd_in, rd_addr1, rd_addr2,
        output wr_en, wr_wnd, wr_addr, wr_data, clr_req, clr_win,
        input  cur_wnd, rd_data1, rd_data2, busy
    );

    modport slave (
        input  ld_wnd, wnd_in, rd_addr1, rd_addr2,
        input  wr_en, wr_wnd, wr_addr, wr_data, clr_req, clr_win,
        output cur_wnd, rd_data1, rd_data2, busy
    );
endinterface

// File: rtl/windowed_reg_file.sv
// Windowed register file: two combinational reads from cur_wnd, one writeback, sequential window clear.
// Define WRF_BYPASS_EN to forward a same-cycle writeback to matching read ports.
//
// state    | meaning
// ST_IDLE  | no clear in progress, clr_req accepted
// ST_CLEAR | zeroing {tgt_q, cnt_q} once per cycle, busy high, clr_req ignored
module windowed_reg_file #(
    parameter int DATA_W       = 16,
    parameter int NUM_WIN      = 4,
    parameter int REGS_PER_WIN = 4,
    parameter int WIN_W        = $clog2(NUM_WIN),
    parameter int ADDR_W       = $clog2(REGS_PER_WIN)
) (
    input  logic                 clk,
    input  logic                 rst,
    windowed_reg_file_if.slave   bus
);
    localparam int DEPTH = NUM_WIN * REGS_PER_WIN;
    localparam int IDX_W = WIN_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REGS_PER_WIN - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0]  tgt_q, tgt_d;
    logic [WIN_W-1:0]  cur_wnd_q, cur_wnd_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx1;
    logic [IDX_W-1:0]  rd_idx2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                    tgt_d   = bus.clr_win;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        clr_we  = 1'b0;
        clr_idx = {tgt_q, cnt_q};
        case (state_q)
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
            end
            default: begin
                busy   = 1'b0;
                clr_we = 1'b0;
            end
        endcase
    end

    always_comb begin
        cur_wnd_d = cur_wnd_q;
        if (bus.ld_wnd) begin
            cur_wnd_d = bus.wnd_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_wnd_q <= '0;
        end else begin
            cur_wnd_q <= cur_wnd_d;
        end
    end

    assign wr_idx = {bus.wr_wnd, bus.wr_addr};

    // The writeback assignment follows the clear so it wins on a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (clr_we) begin
                mem_q[clr_idx] <= '0;
            end
            if (bus.wr_en) begin
                mem_q[wr_idx] <= bus.wr_data;
            end
        end
    end

    assign rd_idx1 = {cur_wnd_q, bus.rd_addr1};
    assign rd_idx2 = {cur_wnd_q, bus.rd_addr2};

`ifdef WRF_BYPASS_EN
    logic hit1, hit2;
    assign hit1 = bus.wr_en && (wr_idx == rd_idx1);
    assign hit2 = bus.wr_en && (wr_idx == rd_idx2);
    assign bus.rd_data1 = hit1 ? bus.wr_data : mem_q[rd_idx1];
    assign bus.rd_data2 = hit2 ? bus.wr_data : mem_q[rd_idx2];
`else
    assign bus.rd_data1 = mem_q[rd_idx1];
    assign bus.rd_data2 = mem_q[rd_idx2];
`endif

    assign bus.cur_wnd = cur_wnd_q;
    assign bus.busy    = busy;
endmodule

// File: tb/tb_windowed_reg_file.sv
// Self-checking bench for windowed_reg_file: directed scenarios then random traffic against a
// window/register array model with a pending-clear queue.
module tb_windowed_reg_file;
    localparam int DW = 16;
    localparam int NW = 4;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    windowed_reg_file_if #(.DATA_W(DW), .NUM_WIN(NW), .REGS_PER_WIN(NR)) bus();

    windowed_reg_file #(.DATA_W(DW), .NUM_WIN(NW), .REGS_PER_WIN(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model
    logic [DW-1:0] m_mem [NW][NR];
    int            m_cur;
    int            m_tgt;
    int            m_pend[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++)
                m_mem[w][r] = '0;
        m_cur = 0;
        m_tgt = 0;
        m_pend.delete();
    endtask

    function automatic logic [DW-1:0] exp_read(input int addr);
        logic [DW-1:0] v;
        v = m_mem[m_cur][addr];
`ifdef WRF_BYPASS_EN
        if (bus.wr_en && int'(bus.wr_wnd) == m_cur && int'(bus.wr_addr) == addr)
            v = bus.wr_data;
`endif
        return v;
    endfunction

    task automatic check_outputs();
        check("cur_wnd", 32'(bus.cur_wnd), 32'(m_cur));
        check("busy", 32'(bus.busy), 32'(m_pend.size() != 0));
        check("rd_data1", 32'(bus.rd_data1), 32'(exp_read(int'(bus.rd_addr1))));
        check("rd_data2", 32'(bus.rd_data2), 32'(exp_read(int'(bus.rd_addr2))));
    endtask

    task automatic model_edge();
        bit was_busy;
        int idx;
        was_busy = (m_pend.size() != 0);
        if (was_busy) begin
            idx = m_pend.pop_front();
            m_mem[m_tgt][idx] = '0;
        end
        if (bus.wr_en) m_mem[bus.wr_wnd][bus.wr_addr] = bus.wr_data;
        if (!was_busy && bus.clr_req) begin
            m_tgt = int'(bus.clr_win);
            for (int i = 0; i < NR; i++) m_pend.push_back(i);
        end
        if (bus.ld_wnd) m_cur = int'(bus.wnd_in);
    endtask

    task automatic tick();
        #1;
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ld_wnd = 0; bus.wnd_in = '0; bus.wr_en = 0; bus.wr_wnd = '0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.clr_req = 0; bus.clr_win = '0;
    endtask

    task automatic write(input int w, input int r, input logic [DW-1:0] d);
        bus.wr_en = 1; bus.wr_wnd = w[1:0]; bus.wr_addr = r[1:0]; bus.wr_data = d;
        tick();
        bus.wr_en = 0;
    endtask

    task automatic set_wnd(input int w);
        bus.ld_wnd = 1; bus.wnd_in = w[1:0];
        tick();
        bus.ld_wnd = 0;
    endtask

    task automatic sweep_all();
        for (int w = 0; w < NW; w++) begin
            set_wnd(w);
            for (int a = 0; a < NR; a++) begin
                bus.rd_addr1 = a[1:0];
                bus.rd_addr2 = 2'(NR - 1 - a);
                #1;
                check_outputs();
            end
        end
    endtask

    initial begin
        int n;
        idle_inputs();
        bus.rd_addr1 = '0; bus.rd_addr2 = '0;
        model_reset();

        // 1: reset
        @(posedge clk); @(posedge clk); #1;
        check("rst_cur_wnd", 32'(bus.cur_wnd), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1;
        sweep_all();

        // 2: windowing
        write(1, 2, 16'hAAAA);
        write(2, 2, 16'h5555);
        set_wnd(1);
        bus.rd_addr1 = 2; #1;
        check("win1_r2", 32'(bus.rd_data1), 32'h0000AAAA);
        set_wnd(2);
        #1;
        check("win2_r2", 32'(bus.rd_data1), 32'h00005555);
        set_wnd(0);
        #1;
        check("win0_r2", 32'(bus.rd_data1), 32'h0);

        // 3: bypass
        set_wnd(1);
        bus.rd_addr2 = 3;
        bus.wr_en = 1; bus.wr_wnd = 1; bus.wr_addr = 3; bus.wr_data = 16'h1234;
        #1;
`ifdef WRF_BYPASS_EN
        check("bypass_same", 32'(bus.rd_data2), 32'h1234);
`else
        check("nobypass_same", 32'(bus.rd_data2), 32'h0);
`endif
        tick();
        bus.wr_en = 0;
        #1;
        check("write_next", 32'(bus.rd_data2), 32'h1234);

        // 4: clear
        for (int r = 0; r < NR; r++) write(3, r, 16'hFFFF);
        bus.clr_req = 1; bus.clr_win = 3;
        tick();
        bus.clr_req = 0;
        n = 0;
        while (bus.busy && n < 20) begin n++; tick(); end
        check("busy_cycles", 32'(n), 32'd4);
        set_wnd(3);
        for (int a = 0; a < NR; a++) begin
            bus.rd_addr1 = a[1:0]; #1;
            check("cleared_w3", 32'(bus.rd_data1), 32'h0);
        end
        sweep_all();

        // 5: collision and ignored request
        for (int r = 0; r < NR; r++) write(3, r, 16'hFFFF);
        bus.clr_req = 1; bus.clr_win = 3;
        tick();
        bus.clr_req = 0;
        for (int k = 0; k < NR; k++) begin
            if (k == 1) begin bus.clr_req = 1; bus.clr_win = 0; end
            if (k == 2) begin bus.wr_en = 1; bus.wr_wnd = 3; bus.wr_addr = 2; bus.wr_data = 16'hBEEF; end
            tick();
            idle_inputs();
        end
        check("busy_after_clr", 32'(bus.busy), 32'd0);
        tick(); tick();
        check("no_extra_busy", 32'(bus.busy), 32'd0);
        set_wnd(3);
        for (int a = 0; a < NR; a++) begin
            bus.rd_addr1 = a[1:0]; #1;
            check("collision_w3", 32'(bus.rd_data1), (a == 2) ? 32'hBEEF : 32'h0);
        end
        sweep_all();

        // 6: reset mid-clear
        bus.clr_req = 1; bus.clr_win = 1;
        tick();
        bus.clr_req = 0;
        tick();
        rst = 0;
        model_reset();
        #1;
        check("midclr_busy", 32'(bus.busy), 32'd0);
        check("midclr_cur", 32'(bus.cur_wnd), 32'd0);
        #2;
        rst = 1;
        tick();
        check("midclr_idle", 32'(bus.busy), 32'd0);
        sweep_all();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.ld_wnd   = ($urandom_range(0, 4) == 0);
            bus.wnd_in   = 2'($urandom);
            bus.rd_addr1 = 2'($urandom);
            bus.rd_addr2 = 2'($urandom);
            bus.wr_en    = $urandom_range(0, 1) == 1;
            bus.wr_wnd   = ($urandom_range(0, 1) == 1) ? 2'(m_cur) : 2'($urandom);
            bus.wr_addr  = 2'($urandom);
            bus.wr_data  = 16'($urandom);
            bus.clr_req  = ($urandom_range(0, 9) == 0);
            bus.clr_win  = 2'($urandom);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) tick();
        sweep_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
